// File: rtl/lc3b_rob_param_if.sv
// Bus bundle between the issue/writeback/retire stages and the reorder buffer.
// The ROB side uses the slave modport; the surrounding pipeline uses master.
interface lc3b_rob_param_if #(
    parameter int unsigned ID_W      = 4,
    parameter int unsigned CDB_PORTS = 2
) ();
    logic                      flush;

    logic                      alloc_valid;
    logic                      alloc_ready;
    logic [3:0]                alloc_opcode;
    logic [2:0]                alloc_dest_reg;
    logic                      alloc_writes_reg;
    logic                      alloc_writes_mem;
    logic                      alloc_modifies_cc;
    logic [ID_W-1:0]           alloc_id;

    logic [CDB_PORTS-1:0]      wb_valid;
    logic [CDB_PORTS*ID_W-1:0] wb_id;
    logic [CDB_PORTS*16-1:0]   wb_data;
    logic [CDB_PORTS*16-1:0]   wb_addr;
    logic [CDB_PORTS*3-1:0]    wb_cc;

    logic [ID_W-1:0]           qj_id;
    logic [ID_W-1:0]           qk_id;
    logic                      qj_ready;
    logic                      qk_ready;
    logic [15:0]               qj_value;
    logic [15:0]               qk_value;

    logic                      commit_valid;
    logic                      commit_ready;
    logic [ID_W-1:0]           commit_id;
    logic [3:0]                commit_opcode;
    logic [15:0]               commit_value;
    logic [15:0]               commit_address;
    logic [2:0]                commit_dest_reg;
    logic [2:0]                commit_cc;
    logic                      commit_modifies_cc;
    logic                      commit_writes_reg;
    logic                      commit_writes_mem;

    logic [ID_W:0]             count;
    logic                      full;
    logic                      empty;

    modport master (
        output flush, alloc_valid, alloc_opcode, alloc_dest_reg, alloc_writes_reg,
               alloc_writes_mem, alloc_modifies_cc, wb_valid, wb_id, wb_data, wb_addr, wb_cc,
               qj_id, qk_id, commit_ready,
        input  alloc_ready, alloc_id, qj_ready, qk_ready, qj_value, qk_value, commit_valid,
               commit_id, commit_opcode, commit_value, commit_address, commit_dest_reg,
               commit_cc, commit_modifies_cc, commit_writes_reg, commit_writes_mem,
               count, full, empty
    );

    modport slave (
        input  flush, alloc_valid, alloc_opcode, alloc_dest_reg, alloc_writes_reg,
               alloc_writes_mem, alloc_modifies_cc, wb_valid, wb_id, wb_data, wb_addr, wb_cc,
               qj_id, qk_id, commit_ready,
        output alloc_ready, alloc_id, qj_ready, qk_ready, qj_value, qk_value, commit_valid,
               commit_id, commit_opcode, commit_value, commit_address, commit_dest_reg,
               commit_cc, commit_modifies_cc, commit_writes_reg, commit_writes_mem,
               count, full, empty
    );
endinterface

// File: rtl/lc3b_rob_param.sv
// Parametrised reorder buffer: in-order alloc and retire, out-of-order writeback from
// several CDB ports, rename operand lookup with same-cycle bypass, single-cycle flush.
module lc3b_rob_param #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned CDB_PORTS = 2
) (
    input logic             clk,
    input logic             rst_n,
    lc3b_rob_param_if.slave rob
);
    localparam int NEnt   = int'(DEPTH);
    localparam int NPorts = int'(CDB_PORTS);

    logic [ID_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [ID_W:0]    count_q, count_d;
    logic [NEnt-1:0]  busy_q, busy_d, done_q, done_d;

    logic [3:0]       opcode_q     [NEnt];
    logic [2:0]       dest_q       [NEnt];
    logic             writes_reg_q [NEnt];
    logic             writes_mem_q [NEnt];
    logic             mod_cc_q     [NEnt];
    logic [15:0]      value_q      [NEnt];
    logic [15:0]      addr_q       [NEnt];
    logic [2:0]       cc_q         [NEnt];

    logic [ID_W-1:0]  wb_id_p   [NPorts];
    logic [15:0]      wb_data_p [NPorts];
    logic [15:0]      wb_addr_p [NPorts];
    logic [2:0]       wb_cc_p   [NPorts];

    logic [NEnt-1:0]  wb_hit;
    logic [15:0]      wb_val_e  [NEnt];
    logic [15:0]      wb_adr_e  [NEnt];
    logic [2:0]       wb_cc_e   [NEnt];

    logic             full, alloc_fire, commit_valid, commit_fire;

    assign full         = (count_q == (ID_W+1)'(DEPTH));
    assign alloc_fire   = rob.alloc_valid && !full && !rob.flush;
    assign commit_valid = busy_q[head_q] && done_q[head_q];
    assign commit_fire  = commit_valid && rob.commit_ready && !rob.flush;

    always_comb begin
        for (int p = 0; p < NPorts; p++) begin
            wb_id_p[p]   = rob.wb_id[p*ID_W +: ID_W];
            wb_data_p[p] = rob.wb_data[p*16 +: 16];
            wb_addr_p[p] = rob.wb_addr[p*16 +: 16];
            wb_cc_p[p]   = rob.wb_cc[p*3 +: 3];
        end
    end

    // Scan ports high to low so the lowest matching port index lands last and wins.
    always_comb begin
        for (int e = 0; e < NEnt; e++) begin
            wb_hit[e]   = 1'b0;
            wb_val_e[e] = '0;
            wb_adr_e[e] = '0;
            wb_cc_e[e]  = '0;
            for (int p = NPorts - 1; p >= 0; p--) begin
                if (rob.wb_valid[p] && busy_q[e] && (wb_id_p[p] == ID_W'(e))) begin
                    wb_hit[e]   = 1'b1;
                    wb_val_e[e] = wb_data_p[p];
                    wb_adr_e[e] = wb_addr_p[p];
                    wb_cc_e[e]  = wb_cc_p[p];
                end
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = done_q | wb_hit;
        if (commit_fire) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_q + ID_W'(1);
        end
        // Applied after writeback so a same-cycle alloc to the same slot leaves done clear.
        if (alloc_fire) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            tail_d         = tail_q + ID_W'(1);
        end
        unique case ({alloc_fire, commit_fire})
            2'b10:   count_d = count_q + (ID_W+1)'(1);
            2'b01:   count_d = count_q - (ID_W+1)'(1);
            default: count_d = count_q;
        endcase
        if (rob.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            busy_d  = '0;
            done_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Payload storage needs no reset: busy/done gate every use of it.
    always_ff @(posedge clk) begin
        for (int e = 0; e < NEnt; e++) begin
            if (wb_hit[e]) begin
                value_q[e] <= wb_val_e[e];
                addr_q[e]  <= wb_adr_e[e];
                cc_q[e]    <= wb_cc_e[e];
            end
            if (alloc_fire && (tail_q == ID_W'(e))) begin
                opcode_q[e]     <= rob.alloc_opcode;
                dest_q[e]       <= rob.alloc_dest_reg;
                writes_reg_q[e] <= rob.alloc_writes_reg;
                writes_mem_q[e] <= rob.alloc_writes_mem;
                mod_cc_q[e]     <= rob.alloc_modifies_cc;
            end
        end
    end

    always_comb begin
        rob.qj_ready = done_q[rob.qj_id] | wb_hit[rob.qj_id];
        rob.qk_ready = done_q[rob.qk_id] | wb_hit[rob.qk_id];
        rob.qj_value = '0;
        rob.qk_value = '0;
        if (wb_hit[rob.qj_id]) begin
            rob.qj_value = wb_val_e[rob.qj_id];
        end else if (done_q[rob.qj_id]) begin
            rob.qj_value = value_q[rob.qj_id];
        end
        if (wb_hit[rob.qk_id]) begin
            rob.qk_value = wb_val_e[rob.qk_id];
        end else if (done_q[rob.qk_id]) begin
            rob.qk_value = value_q[rob.qk_id];
        end
    end

    assign rob.alloc_ready        = !full;
    assign rob.alloc_id           = tail_q;
    assign rob.commit_valid       = commit_valid;
    assign rob.commit_id          = head_q;
    assign rob.commit_opcode      = opcode_q[head_q];
    assign rob.commit_value       = value_q[head_q];
    assign rob.commit_address     = addr_q[head_q];
    assign rob.commit_dest_reg    = dest_q[head_q];
    assign rob.commit_cc          = cc_q[head_q];
    assign rob.commit_modifies_cc = mod_cc_q[head_q];
    assign rob.commit_writes_reg  = writes_reg_q[head_q];
    assign rob.commit_writes_mem  = writes_mem_q[head_q];
    assign rob.count              = count_q;
    assign rob.full               = full;
    assign rob.empty              = (count_q == '0);
endmodule

// File: tb/tb_lc3b_rob_param.sv
// Directed and randomised bench for lc3b_rob_param against a queue-based model of
// in-order allocation and retirement.
module tb_lc3b_rob_param;
    localparam int DEPTH = 16;
    localparam int ID_W  = 4;
    localparam int NP    = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lc3b_rob_param_if #(.ID_W(ID_W), .CDB_PORTS(NP)) bus ();

    lc3b_rob_param #(.DEPTH(DEPTH), .ID_W(ID_W), .CDB_PORTS(NP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rob   (bus.slave)
    );

    typedef struct {
        int          id;
        logic [3:0]  op;
        logic [2:0]  dest;
        logic        wr, wm, mc, done;
        logic [15:0] val, addr;
        logic [2:0]  cc;
    } ent_t;

    ent_t q[$];
    int   head_m = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int find(input int id);
        for (int i = 0; i < q.size(); i++) if (q[i].id == id) return i;
        return -1;
    endfunction

    function automatic int wb_port_for(input int id);
        for (int p = 0; p < NP; p++)
            if (bus.wb_valid[p] && int'(bus.wb_id[p*ID_W +: ID_W]) == id) return p;
        return -1;
    endfunction

    task automatic idle();
        bus.flush = 0; bus.alloc_valid = 0; bus.alloc_opcode = 0; bus.alloc_dest_reg = 0;
        bus.alloc_writes_reg = 0; bus.alloc_writes_mem = 0; bus.alloc_modifies_cc = 0;
        bus.wb_valid = '0; bus.wb_id = '0; bus.wb_data = '0; bus.wb_addr = '0; bus.wb_cc = '0;
        bus.qj_id = 0; bus.qk_id = 0; bus.commit_ready = 0;
    endtask

    task automatic set_alloc(input logic [3:0] op, input logic [2:0] dest);
        bus.alloc_valid = 1; bus.alloc_opcode = op; bus.alloc_dest_reg = dest;
        bus.alloc_writes_reg = 1; bus.alloc_writes_mem = 0; bus.alloc_modifies_cc = 1;
    endtask

    task automatic set_wb(input int p, input int id, input logic [15:0] d);
        bus.wb_valid[p] = 1;
        bus.wb_id[p*ID_W +: ID_W] = ID_W'(id);
        bus.wb_data[p*16 +: 16] = d;
        bus.wb_addr[p*16 +: 16] = ~d;
        bus.wb_cc[p*3 +: 3] = d[2:0];
    endtask

    // Check the combinational view against the model, advance the model, then clock.
    task automatic tick();
        int   tail_pre, idx, p, lid;
        logic cv, lready;
        logic [15:0] lval;
        #1;
        cv = (q.size() > 0) && q[0].done;
        chk("alloc_ready", bus.alloc_ready, q.size() < DEPTH);
        chk("alloc_id", bus.alloc_id, (head_m + q.size()) % DEPTH);
        chk("count", bus.count, q.size());
        chk("full", bus.full, q.size() == DEPTH);
        chk("empty", bus.empty, q.size() == 0);
        chk("commit_valid", bus.commit_valid, cv);
        if (cv) begin
            chk("commit_id", bus.commit_id, q[0].id);
            chk("commit_opcode", bus.commit_opcode, q[0].op);
            chk("commit_value", bus.commit_value, q[0].val);
            chk("commit_address", bus.commit_address, q[0].addr);
            chk("commit_dest", bus.commit_dest_reg, q[0].dest);
            chk("commit_cc", bus.commit_cc, q[0].cc);
            chk("commit_flags", {bus.commit_writes_reg, bus.commit_writes_mem,
                bus.commit_modifies_cc}, {q[0].wr, q[0].wm, q[0].mc});
        end
        for (int k = 0; k < 2; k++) begin
            lid = (k == 0) ? int'(bus.qj_id) : int'(bus.qk_id);
            idx = find(lid);
            lready = 0; lval = 0;
            if (idx >= 0) begin
                p = wb_port_for(lid);
                if (p >= 0) begin lready = 1; lval = bus.wb_data[p*16 +: 16]; end
                else if (q[idx].done) begin lready = 1; lval = q[idx].val; end
            end
            chk(k == 0 ? "qj_ready" : "qk_ready", k == 0 ? bus.qj_ready : bus.qk_ready, lready);
            if (lready || idx < 0)
                chk(k == 0 ? "qj_value" : "qk_value", k == 0 ? bus.qj_value : bus.qk_value, lval);
        end
        if (!rst_n || bus.flush) begin
            q.delete();
            head_m = 0;
        end else begin
            tail_pre = (head_m + q.size()) % DEPTH;
            for (int i = 0; i < q.size(); i++) begin
                p = wb_port_for(q[i].id);
                if (p >= 0) begin
                    q[i].done = 1;
                    q[i].val  = bus.wb_data[p*16 +: 16];
                    q[i].addr = bus.wb_addr[p*16 +: 16];
                    q[i].cc   = bus.wb_cc[p*3 +: 3];
                end
            end
            if (bus.alloc_valid && q.size() < DEPTH) begin
                ent_t n;
                n.id = tail_pre; n.op = bus.alloc_opcode; n.dest = bus.alloc_dest_reg;
                n.wr = bus.alloc_writes_reg; n.wm = bus.alloc_writes_mem;
                n.mc = bus.alloc_modifies_cc; n.done = 0; n.val = 0; n.addr = 0; n.cc = 0;
                if (cv && bus.commit_ready) begin
                    void'(q.pop_front());
                    head_m = (head_m + 1) % DEPTH;
                end
                q.push_back(n);
            end else if (cv && bus.commit_ready) begin
                void'(q.pop_front());
                head_m = (head_m + 1) % DEPTH;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_alloc_ready", bus.alloc_ready, 1);
        chk("rst_commit_valid", bus.commit_valid, 0);

        // Fill all 16 slots, then a 17th request must bounce.
        for (int i = 0; i < DEPTH; i++) begin
            idle(); set_alloc(4'b0001, 3'((i % 7) + 1));
            #1 chk("fill_id", bus.alloc_id, i);
            tick();
        end
        chk("full16", bus.full, 1);
        chk("full_alloc_ready", bus.alloc_ready, 0);
        idle(); set_alloc(4'b0001, 3'd1); tick();
        chk("count_after_17th", bus.count, 16);

        // Retire one while allocating when full: alloc rejected, then wraps to id 0.
        idle(); set_wb(0, 0, 16'h1234); tick();
        idle(); set_alloc(4'b0101, 3'd2); bus.commit_ready = 1; tick();
        chk("retire_full_count", bus.count, 15);
        chk("retire_full_ready", bus.alloc_ready, 1);
        idle(); set_alloc(4'b0101, 3'd2);
        #1 chk("wrap_id", bus.alloc_id, 0);
        tick();
        chk("wrap_count", bus.count, 16);

        // Flush beats a concurrent alloc and writeback with 5 busy entries.
        idle(); bus.flush = 1; tick();
        for (int i = 0; i < 5; i++) begin idle(); set_alloc(4'b0001, 3'd3); tick(); end
        idle(); bus.flush = 1; set_alloc(4'b0001, 3'd4); set_wb(0, 1, 16'hBEEF); tick();
        chk("flush_count", bus.count, 0);
        chk("flush_empty", bus.empty, 1);
        idle(); set_alloc(4'b0001, 3'd4);
        #1 chk("flush_next_id", bus.alloc_id, 0);
        tick();

        // Out-of-order writeback, in-order retire with id1 blocking.
        idle(); bus.flush = 1; tick();
        for (int i = 0; i < 3; i++) begin idle(); set_alloc(4'b0001, 3'(i + 1)); tick(); end
        idle(); set_wb(0, 2, 16'h0022); set_wb(1, 0, 16'h0011); tick();
        chk("ooo_commit_valid", bus.commit_valid, 1);
        chk("ooo_commit_value", bus.commit_value, 16'h0011);
        idle(); bus.commit_ready = 1; tick();
        chk("blocked_valid", bus.commit_valid, 0);
        idle(); bus.commit_ready = 1; tick();
        idle(); bus.commit_ready = 1; set_wb(0, 1, 16'h0033); tick();
        chk("unblock_value", bus.commit_value, 16'h0033);
        idle(); bus.commit_ready = 1; tick();
        chk("id2_value", bus.commit_value, 16'h0022);
        idle(); bus.commit_ready = 1; tick();
        chk("drained", bus.empty, 1);

        // Two ports hit id3 in one cycle: port 0 wins, bypass sees it too.
        idle(); set_alloc(4'b0110, 3'd5); tick();
        idle(); set_wb(0, 3, 16'hAAAA); set_wb(1, 3, 16'h5555); bus.qj_id = 3;
        #1 chk("bypass_ready", bus.qj_ready, 1);
        chk("bypass_value", bus.qj_value, 16'hAAAA);
        tick();
        chk("dual_wb_value", bus.commit_value, 16'hAAAA);

        // Reset mid-stream with a retirable head.
        idle(); set_alloc(4'b0001, 3'd6); bus.commit_ready = 1; rst_n = 0; tick();
        rst_n = 1;
        chk("midrst_count", bus.count, 0);
        chk("midrst_commit_valid", bus.commit_valid, 0);
        chk("midrst_empty", bus.empty, 1);
        chk("midrst_alloc_ready", bus.alloc_ready, 1);
        chk("midrst_alloc_id", bus.alloc_id, 0);

        // Randomised traffic.
        for (int c = 0; c < 800; c++) begin
            idle();
            rst_n = ($urandom_range(0, 299) != 0);
            bus.flush = ($urandom_range(0, 59) == 0);
            bus.alloc_valid = ($urandom_range(0, 9) < 6);
            bus.alloc_opcode = 4'($urandom);
            bus.alloc_dest_reg = 3'($urandom);
            bus.alloc_writes_reg = 1'($urandom);
            bus.alloc_writes_mem = 1'($urandom);
            bus.alloc_modifies_cc = 1'($urandom);
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 2) != 0) begin
                    int id;
                    id = (q.size() > 0 && $urandom_range(0, 3) != 0)
                        ? q[$urandom_range(0, q.size() - 1)].id : int'($urandom_range(0, DEPTH - 1));
                    set_wb(p, id, 16'($urandom));
                end
            end
            bus.commit_ready = ($urandom_range(0, 3) != 0);
            bus.qj_id = (q.size() > 0) ? ID_W'(q[$urandom_range(0, q.size() - 1)].id)
                                       : ID_W'($urandom);
            bus.qk_id = ($urandom_range(0, 1) == 0) ? bus.wb_id[ID_W-1:0] : ID_W'($urandom);
            tick();
        end
        rst_n = 1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
